peripheral_responder: RTL and testbench

- Device-side endpoint of the peripheral bus. Each peripheral gets one instance, which answers the CPU-side bus master.
- Decodes the device/command/data presented by the master. Matches its own DEVICE_ID. Performs a read or write on a local 8x32 register bank. Returns data with a one-cycle ack pulse.
- Exposes register 0 (control) to the attached peripheral logic. Maps a live status input as read-only register 7.

---
 rtl/peripheral_bus_pkg.sv | 41 ++++
 rtl/peripheral_responder_if.sv | 23 ++
 rtl/peripheral_responder_regbank.sv | 52 +++++
 rtl/peripheral_responder.sv | 133 +++++++++++++
 tb/tb_peripheral_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus responder: field widths, op codes,
// register indices, FSM state encoding and the command payload layout.
package peripheral_bus_pkg;

    localparam int unsigned DEV_W    = 5;
    localparam int unsigned CMD_W    = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned WAIT_W   = 4;

    localparam logic [OP_W-1:0]  OP_READ    = 3'b000;
    localparam logic [OP_W-1:0]  OP_WRITE   = 3'b001;
    localparam logic [IDX_W-1:0] STATUS_IDX = 3'd7;
    localparam logic [IDX_W-1:0] CTRL_IDX   = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Command word as presented on the bus: op in the upper bits, index below.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    // An access errors when the op is not read/write, or when it writes the
    // read-only status slot.
    function automatic logic cmd_is_error(input cmd_t cmd);
        logic legal;
        legal = (cmd.op == OP_READ) ||
                ((cmd.op == OP_WRITE) && (cmd.idx != STATUS_IDX));
        return !legal;
    endfunction

endpackage

// File: rtl/peripheral_responder_if.sv
// Master/device handshake of the peripheral bus.
interface peripheral_responder_if;
    import peripheral_bus_pkg::*;

    logic              req;
    logic [DEV_W-1:0]  device;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              err;

    modport master (
        output req, device, command, data_in,
        input  data_out, ack, err
    );

    modport slave (
        input  req, device, command, data_in,
        output data_out, ack, err
    );

endinterface

// File: rtl/peripheral_responder_regbank.sv
// 8x32 register bank of the responder. Slots 0..6 are storage, slot 7 is the
// live status input; slot 0 is also exported as the control word.
module responder_regbank
    import peripheral_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    input  logic [DATA_W-1:0] status_in,
    output logic [DATA_W-1:0] rdata_c,
    output logic [DATA_W-1:0] ctrl
);

    localparam int unsigned STORE_N = NUM_REGS - 1;

    logic [DATA_W-1:0] regs [STORE_N];

    // Storage slots; a write aimed at the status slot matches no entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < STORE_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STORE_N; i++) begin
                if (we && (widx == IDX_W'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Read mux: status slot maps straight to the live input.
    always_comb begin
        rdata_c = '0;
        if (ridx == STATUS_IDX) begin
            rdata_c = status_in;
        end else begin
            for (int unsigned i = 0; i < STORE_N; i++) begin
                if (ridx == IDX_W'(i)) begin
                    rdata_c = regs[i];
                end
            end
        end
    end

    assign ctrl = regs[CTRL_IDX];

endmodule

// File: rtl/peripheral_responder.sv
// Device-side endpoint of the peripheral bus: decodes a request addressed to
// DEVICE_ID, performs a read/write on the local register bank and answers with
// a one-cycle ack. Optional slow-peripheral wait states are built when
// PERIPHERAL_RESPONDER_WAIT_STATES_EN is defined (WAIT_CYCLES extra cycles).
module peripheral_responder
    import peripheral_bus_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEVICE_ID   = 5'd1,
    parameter int unsigned      WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    peripheral_responder_if.slave bus,
    input  logic [DATA_W-1:0]     status_in,
    output logic [DATA_W-1:0]     ctrl_out
);

    if (WAIT_CYCLES > 15) begin : g_wait_range_check
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_e            state;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] wdata_q;

    logic              bank_we_c;
    logic [DATA_W-1:0] bank_rdata_c;
    logic              access_err_c;
    logic [DATA_W-1:0] access_data_c;

`ifdef PERIPHERAL_RESPONDER_WAIT_STATES_EN
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;
`endif

    // Access decode from the command latched in IDLE.
    assign access_err_c  = cmd_is_error(cmd_q);
    assign bank_we_c     = (state == ST_ACCESS) && (cmd_q.op == OP_WRITE) && !access_err_c;
    assign access_data_c = (cmd_q.op == OP_READ) ? bank_rdata_c : '0;

    responder_regbank u_regbank (
        .clk       (clk),
        .reset     (reset),
        .we        (bank_we_c),
        .widx      (cmd_q.idx),
        .wdata     (wdata_q),
        .ridx      (cmd_q.idx),
        .status_in (status_in),
        .rdata_c   (bank_rdata_c),
        .ctrl      (ctrl_out)
    );

    // Handshake FSM with registered ack/err/data_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cmd_q        <= '0;
            wdata_q      <= '0;
            bus.ack      <= 1'b0;
            bus.err      <= 1'b0;
            bus.data_out <= '0;
`ifdef PERIPHERAL_RESPONDER_WAIT_STATES_EN
            wait_cnt     <= '0;
            resp_err     <= 1'b0;
            resp_data    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req && (bus.device == DEVICE_ID)) begin
                        cmd_q   <= cmd_t'(bus.command);
                        wdata_q <= bus.data_in;
                        state   <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
`ifdef PERIPHERAL_RESPONDER_WAIT_STATES_EN
                    if (WAIT_LOAD != '0) begin
                        wait_cnt  <= WAIT_LOAD;
                        resp_err  <= access_err_c;
                        resp_data <= access_data_c;
                        state     <= ST_WAIT;
                    end else begin
                        bus.ack      <= 1'b1;
                        bus.err      <= access_err_c;
                        bus.data_out <= access_data_c;
                        state        <= ST_RESPOND;
                    end
`else
                    bus.ack      <= 1'b1;
                    bus.err      <= access_err_c;
                    bus.data_out <= access_data_c;
                    state        <= ST_RESPOND;
`endif
                end

`ifdef PERIPHERAL_RESPONDER_WAIT_STATES_EN
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        bus.ack      <= 1'b1;
                        bus.err      <= resp_err;
                        bus.data_out <= resp_data;
                        state        <= ST_RESPOND;
                    end
                end
`endif

                ST_RESPOND: begin
                    bus.ack      <= 1'b0;
                    bus.err      <= 1'b0;
                    bus.data_out <= '0;
                    state        <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    if (!bus.req) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_responder.sv
// Self-checking bench for peripheral_responder: directed vector table,
// hand-written reset-abort sequence, then random traffic against a model.
module tb_peripheral_responder;
    import peripheral_bus_pkg::*;

    localparam logic [4:0] DUT_ID = 5'd1;
    localparam int         WAIT_N = 4;
`ifdef PERIPHERAL_RESPONDER_WAIT_STATES_EN
    localparam int LAT = 2 + WAIT_N;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] status_in;
    logic [31:0] ctrl_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_regs [8];

    peripheral_responder_if bus ();

    peripheral_responder #(
        .DEVICE_ID   (DUT_ID),
        .WAIT_CYCLES (WAIT_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .status_in (status_in),
        .ctrl_out  (ctrl_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dev;
        logic [2:0]  op;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] status;
        int          hold;
        int          exp_acks;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_ctrl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one request and watch the bus for a bounded window.
    // hold=0: drop req once ack is seen; hold=k: keep req high for k edges.
    task automatic run_txn(input logic [4:0] dev, input logic [2:0] op, input logic [2:0] idx,
                           input logic [31:0] wdata, input logic [31:0] status, input int hold,
                           output int acks, output int lat, output logic e,
                           output logic [31:0] d, output int leaks);
        int win;
        bit req_on;
        acks = 0; lat = -1; e = 1'b0; d = '0; leaks = 0;
        win = (hold + 6 > LAT + 8) ? hold + 6 : LAT + 8;
        @(negedge clk);
        bus.req     = 1'b1;
        bus.device  = dev;
        bus.command = {op, idx};
        bus.data_in = wdata;
        status_in   = status;
        req_on      = 1'b1;
        for (int c = 1; c <= win; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack) begin
                if (acks == 0) begin
                    lat = c;
                    e   = bus.err;
                    d   = bus.data_out;
                end
                acks++;
            end else if (bus.data_out != '0) begin
                leaks++;
            end
            if (req_on && ((hold == 0 && acks > 0) || (hold > 0 && c >= hold))) begin
                bus.req     = 1'b0;
                bus.device  = 5'($urandom);
                bus.command = 6'($urandom);
                bus.data_in = $urandom;
                req_on      = 1'b0;
            end
        end
        bus.req = 1'b0;
    endtask

    // Random transaction checked against the bank model.
    task automatic model_txn(input int n, input logic [4:0] dev, input logic [2:0] op,
                             input logic [2:0] idx, input logic [31:0] wdata,
                             input logic [31:0] status, input int hold);
        bit          hit;
        logic        exp_err;
        logic [31:0] exp_data;
        int acks, lat, leaks;
        logic e;
        logic [31:0] d;
        hit      = (dev == DUT_ID);
        exp_err  = (op > 3'd1) || (op == 3'd1 && idx == 3'd7);
        exp_data = '0;
        if (op == 3'd0) exp_data = (idx == 3'd7) ? status : model_regs[idx];
        run_txn(dev, op, idx, wdata, status, hold, acks, lat, e, d, leaks);
        check($sformatf("rnd%0d_acks", n), 32'(acks), hit ? 32'd1 : 32'd0);
        if (hit && acks > 0) begin
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(LAT));
            check($sformatf("rnd%0d_err", n), 32'(e), 32'(exp_err));
            check($sformatf("rnd%0d_data", n), d, exp_data);
        end
        check($sformatf("rnd%0d_leak", n), 32'(leaks), 32'd0);
        if (hit && op == 3'd1 && idx != 3'd7) model_regs[idx] = wdata;
        check($sformatf("rnd%0d_ctrl", n), ctrl_out, model_regs[0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        int acks, lat, leaks, rst_acks;
        logic e;
        logic [31:0] d;

        //            dev    op      idx   wdata         status        hold acks err   data          ctrl
        vecs[0]  = '{5'd1, 3'b001, 3'd0, 32'hDEADBEEF, 32'h0,        0,   1, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{5'd1, 3'b000, 3'd0, 32'h0,        32'h0,        0,   1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{5'd2, 3'b001, 3'd0, 32'h11111111, 32'h0,        10,  0, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{5'd1, 3'b001, 3'd7, 32'hCAFEF00D, 32'h0,        0,   1, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{5'd1, 3'b111, 3'd0, 32'h00000055, 32'h0,        0,   1, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{5'd1, 3'b000, 3'd7, 32'h0,        32'h000000A5, 0,   1, 1'b0, 32'h000000A5, 32'hDEADBEEF};
        vecs[6]  = '{5'd1, 3'b001, 3'd3, 32'h0BADF00D, 32'h0,        1,   1, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[7]  = '{5'd1, 3'b000, 3'd3, 32'h0,        32'h0,        0,   1, 1'b0, 32'h0BADF00D, 32'hDEADBEEF};
        vecs[8]  = '{5'd1, 3'b010, 3'd3, 32'h0,        32'h0,        0,   1, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[9]  = '{5'd1, 3'b001, 3'd0, 32'h600DCAFE, 32'h0,        20,  1, 1'b0, 32'h0,        32'h600DCAFE};
        vecs[10] = '{5'd1, 3'b000, 3'd0, 32'h0,        32'hFFFFFFFF, 0,   1, 1'b0, 32'h600DCAFE, 32'h600DCAFE};
        vecs[11] = '{5'd0, 3'b000, 3'd0, 32'h0,        32'h0,        0,   0, 1'b0, 32'h0,        32'h600DCAFE};

        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        reset       = 1'b0;
        bus.req     = 1'b0;
        bus.device  = '0;
        bus.command = '0;
        bus.data_in = '0;
        status_in   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_data", bus.data_out, 32'd0);
        check("rst_ctrl", ctrl_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ack", 32'(bus.ack), 32'd0);
        check("post_rst_ctrl", ctrl_out, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].dev, vecs[i].op, vecs[i].idx, vecs[i].wdata, vecs[i].status,
                    vecs[i].hold, acks, lat, e, d, leaks);
            check($sformatf("vec%0d_acks", i), 32'(acks), 32'(vecs[i].exp_acks));
            if (vecs[i].exp_acks > 0) begin
                check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
                check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            end
            check($sformatf("vec%0d_leak", i), 32'(leaks), 32'd0);
            check($sformatf("vec%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
            if (vecs[i].exp_acks > 0 && vecs[i].op == 3'b001 && vecs[i].idx != 3'd7)
                model_regs[vecs[i].idx] = vecs[i].wdata;
        end

        // Reset asserted while a write to the control register is in ACCESS.
        @(negedge clk);
        bus.req     = 1'b1;
        bus.device  = DUT_ID;
        bus.command = {OP_WRITE, 3'd0};
        bus.data_in = 32'h00001234;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.ack), 32'd0);
        check("midrst_ctrl", ctrl_out, 32'd0);
        check("midrst_data", bus.data_out, 32'd0);
        @(negedge clk);
        bus.req = 1'b0;
        reset   = 1'b1;
        rst_acks = 0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (bus.ack) rst_acks++;
        end
        check("midrst_no_ack", 32'(rst_acks), 32'd0);
        check("midrst_ctrl_after", ctrl_out, 32'd0);
        for (int i = 0; i < 8; i++) model_regs[i] = '0;

        for (int n = 0; n < 200; n++) begin
            logic [4:0]  dev;
            logic [2:0]  op;
            int          sel;
            int          hold;
            dev  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : DUT_ID;
            sel  = $urandom_range(0, 9);
            op   = (sel < 4) ? 3'b000 : (sel < 8) ? 3'b001 : 3'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            model_txn(n, dev, op, 3'($urandom), $urandom, $urandom, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
